// File: rtl/depac_pe_fifo.sv
// ---------------------------------------------------------------------------
// depac_pe_fifo
//   Clocked depacketizer between the NOC and a function unit. It accepts NOC
//   flits over valid/ready, strips the destination-address field and queues
//   {type, payload} in a DEPTH-entry first-word-fall-through FIFO.
//
//   Flit layout: {type[TYPE_W], addr[ADDR_W], payload[DATA_W]}
//
//   Optional feature macro: DEPAC_ADDR_CHECK_EN
//     defined   : accepted flits whose addr field != cfg_addr are dropped and
//                 counted in drop_cnt (saturating at 16'hFFFF).
//     undefined : every accepted flit is queued; drop_cnt is tied to 0.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid/in_ready     NOC flit handshake
//   in_pkt   [PKT_W]      NOC flit
//   cfg_addr [ADDR_W]     this PE's address (quasi-static)
//   out_valid/out_ready   function-unit handshake on the FIFO head
//   out_data [OUT_W]      {type, payload} of the FIFO head, 0 when empty
//   fifo_count [CNT_W]    occupied entries
//   drop_cnt [16]         flits rejected by the address filter
// ---------------------------------------------------------------------------
module depac_pe_fifo #(
    parameter  int PKT_W  = 32,
    parameter  int TYPE_W = 2,
    parameter  int ADDR_W = 6,
    parameter  int DEPTH  = 4,
    localparam int DATA_W = PKT_W - TYPE_W - ADDR_W,
    localparam int OUT_W  = TYPE_W + DATA_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PKT_W-1:0]  in_pkt,
    input  logic [ADDR_W-1:0] cfg_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [CNT_W-1:0]  fifo_count,
    output logic [15:0]       drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [TYPE_W-1:0] ptype;
        logic [DATA_W-1:0] payload;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    entry_t            in_entry;
    logic [ADDR_W-1:0] in_addr;
    logic              accept;
    logic              addr_ok;
    logic              push;
    logic              pop;

    assign in_entry.ptype   = in_pkt[PKT_W-1 -: TYPE_W];
    assign in_entry.payload = in_pkt[DATA_W-1:0];
    assign in_addr          = in_pkt[DATA_W +: ADDR_W];

    // Ready depends on the count register only: a full FIFO stalls the NOC
    // even if the head is being popped this cycle (no full-bypass).
    assign in_ready  = (fifo_count != CNT_W'(DEPTH));
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? OUT_W'(mem[rd_ptr]) : '0;

    assign accept = in_valid & in_ready;
    assign push   = accept & addr_ok;
    assign pop    = out_valid & out_ready;

`ifdef DEPAC_ADDR_CHECK_EN
    assign addr_ok = (in_addr == cfg_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && !addr_ok && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    logic unused_addr;

    assign addr_ok     = 1'b1;
    assign drop_cnt    = '0;
    assign unused_addr = ^{in_addr, cfg_addr};
`endif

    // Storage is deliberately not reset; validity is tracked by fifo_count.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_depac_pe_fifo.sv
// ---------------------------------------------------------------------------
// tb_depac_pe_fifo
//   Directed bench for depac_pe_fifo (default parameters, DEPTH=4). Inputs are
//   driven #1 after the rising edge and outputs are sampled there as well.
//   Ends with a short random-backpressure run against a queue scoreboard.
// ---------------------------------------------------------------------------
module tb_depac_pe_fifo;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pkt;
    logic [5:0]  cfg_addr;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_data;
    logic [2:0]  fifo_count;
    logic [15:0] drop_cnt;

    int errs;
    int checks;

    depac_pe_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pkt     (in_pkt),
        .cfg_addr   (cfg_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Test flit i: type = i[1:0], addr = 0, payload = 24'h100000 + i
    function automatic logic [31:0] mk(input int i);
        logic [23:0] p;
        logic [1:0]  t;
        p = 24'h100000 + 24'(i);
        t = 2'(i);
        return {t, 6'h00, p};
    endfunction

    function automatic logic [25:0] ex(input int i);
        logic [23:0] p;
        logic [1:0]  t;
        p = 24'h100000 + 24'(i);
        t = 2'(i);
        return {t, p};
    endfunction

    logic [25:0] sb[$];
    logic [25:0] prev_data;
    logic        prev_hold;

    initial begin
        errs = 0; checks = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_pkt = '0; cfg_addr = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        rst_n = 1'b1;

        // 1 basic
        out_ready = 1'b1; in_valid = 1'b1; in_pkt = 32'hC0ABCDEF;
        tick();
        in_valid = 1'b0;
        chk("basic_valid", 32'(out_valid), 1);
        chk("basic_data", 32'(out_data), 32'h3ABCDEF);
        chk("basic_count", 32'(fifo_count), 1);
        tick();
        chk("basic_count_pop", 32'(fifo_count), 0);
        chk("basic_valid_pop", 32'(out_valid), 0);
        chk("basic_data_pop", 32'(out_data), 0);

        // 2 fill and drain
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_pkt = mk(i);
            tick();
        end
        chk("fill_count", 32'(fifo_count), 4);
        chk("fill_in_ready", 32'(in_ready), 0);
        in_pkt = mk(4);
        tick();
        chk("fill_held_count", 32'(fifo_count), 4);
        chk("fill_held_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        chk("drain_head0", 32'(out_data), 32'(ex(0)));
        tick();
        chk("drain_count3", 32'(fifo_count), 3);
        chk("drain_in_ready", 32'(in_ready), 1);
        chk("drain_head1", 32'(out_data), 32'(ex(1)));
        tick();
        in_valid = 1'b0;
        chk("drain_count_pp", 32'(fifo_count), 3);
        for (int k = 2; k <= 4; k++) begin
            chk($sformatf("drain_head%0d", k), 32'(out_data), 32'(ex(k)));
            tick();
        end
        chk("drain_empty", 32'(fifo_count), 0);

        // 3 concurrent push/pop across pointer wrap
        out_ready = 1'b0;
        for (int i = 10; i < 12; i++) begin
            in_valid = 1'b1; in_pkt = mk(i);
            tick();
        end
        chk("conc_count", 32'(fifo_count), 2);
        out_ready = 1'b1;
        for (int k = 12; k < 24; k++) begin
            chk($sformatf("conc_head%0d", k - 2), 32'(out_data), 32'(ex(k - 2)));
            in_pkt = mk(k);
            tick();
            chk($sformatf("conc_count%0d", k), 32'(fifo_count), 2);
        end
        in_valid = 1'b0;
        for (int k = 22; k < 24; k++) begin
            chk($sformatf("conc_tail%0d", k), 32'(out_data), 32'(ex(k)));
            tick();
        end
        chk("conc_empty", 32'(fifo_count), 0);

        // 4 address filter
        cfg_addr = 6'd0; in_valid = 1'b1; in_pkt = 32'h05123456;
        tick();
        in_valid = 1'b0;
`ifdef DEPAC_ADDR_CHECK_EN
        chk("filt_drop_valid", 32'(out_valid), 0);
        chk("filt_drop_cnt", 32'(drop_cnt), 1);
`else
        chk("filt_pass_valid", 32'(out_valid), 1);
        chk("filt_pass_data", 32'(out_data), 32'h0123456);
        chk("filt_pass_cnt", 32'(drop_cnt), 0);
        tick();
`endif
        cfg_addr = 6'd5; in_valid = 1'b1; in_pkt = 32'h05123456;
        tick();
        in_valid = 1'b0;
        chk("filt_match_valid", 32'(out_valid), 1);
        chk("filt_match_data", 32'(out_data), 32'h0123456);
`ifdef DEPAC_ADDR_CHECK_EN
        chk("filt_match_cnt", 32'(drop_cnt), 1);
`else
        chk("filt_match_cnt", 32'(drop_cnt), 0);
`endif
        tick();
        chk("filt_empty", 32'(fifo_count), 0);
        cfg_addr = 6'd0;

        // 5 reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pkt = mk(40 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("rm_count3", 32'(fifo_count), 3);
        rst_n = 1'b0;
        tick();
        chk("rm_count", 32'(fifo_count), 0);
        chk("rm_out_valid", 32'(out_valid), 0);
        chk("rm_out_data", 32'(out_data), 0);
        chk("rm_in_ready", 32'(in_ready), 1);
        chk("rm_drop_cnt", 32'(drop_cnt), 0);
        rst_n = 1'b1;
        in_valid = 1'b1; in_pkt = mk(30);
        tick();
        in_valid = 1'b0;
        chk("rm_first_data", 32'(out_data), 32'(ex(30)));
        chk("rm_first_count", 32'(fifo_count), 1);
        out_ready = 1'b1;
        tick();
        chk("rm_after_pop", 32'(fifo_count), 0);

        // 6 random backpressure against a scoreboard
        prev_hold = 1'b0; prev_data = '0;
        for (int c = 0; c < 300; c++) begin
            logic        v;
            logic        r;
            logic [1:0]  t;
            logic [23:0] p;
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 2) == 0);
            t = 2'($urandom);
            p = 24'($urandom);
            in_valid = v; out_ready = r; in_pkt = {t, 6'h00, p};
            chk("rnd_in_ready", 32'(in_ready), 32'(sb.size() != 4));
            chk("rnd_out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) chk("rnd_data", 32'(out_data), 32'(sb[0]));
            if (prev_hold) chk("rnd_stable", 32'(out_data), 32'(prev_data));
            prev_hold = (sb.size() != 0) && !r;
            prev_data = (sb.size() != 0) ? sb[0] : '0;
            tick();
            begin
                bit do_pop;
                bit do_push;
                do_pop  = r && sb.size() != 0;
                do_push = v && sb.size() != 4;
                if (do_pop)  void'(sb.pop_front());
                if (do_push) sb.push_back({t, p});
            end
        end
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
